// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the five user pushbuttons into one-cycle press pulses.
// Up/down auto-repeat while held; holding both at once silences them.
module button_conditioner #(
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dw,
  input  logic btn_lf,
  input  logic btn_rg,
  input  logic btn_prom,
  output logic up,
  output logic dw,
  output logic lf,
  output logic rg,
  output logic prom
);

  localparam int NB      = 5;
  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES);
  localparam logic [RW-1:0] REP_DLY_LD = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_PER_LD = RW'(REP_PERIOD - 1);

  // bit order: 0 up, 1 dw, 2 lf, 3 rg, 4 prom
  logic [NB-1:0] raw;
  assign raw = {btn_prom, btn_rg, btn_lf, btn_dw, btn_up};

  logic [NB-1:0]         sync1_q, sync1_d;
  logic [NB-1:0]         sync2_q, sync2_d;
  logic [NB-1:0]         stable_q, stable_d;
  logic [NB-1:0]         stable_dly_q, stable_dly_d;
  logic [NB-1:0]         out_q, out_d;
  logic [NB-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            rep_active_q, rep_active_d;
  logic [1:0][RW-1:0]    rep_cnt_q, rep_cnt_d;
  logic [NB-1:0]         press;
  logic                  conflict;

  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    deb_cnt_d    = deb_cnt_q;

    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        stable_d[i]  = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end

    // Conflict is judged on the stable levels that will hold while the output is visible.
    conflict = stable_d[0] & stable_d[1];
    press    = stable_q & ~stable_dly_q;
    if (conflict || (press[0] && press[1])) begin
      press[1:0] = 2'b00;
    end
    out_d = press;

    rep_active_d = rep_active_q;
    rep_cnt_d    = rep_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (conflict || !stable_d[i]) begin
        rep_active_d[i] = 1'b0;
        rep_cnt_d[i]    = '0;
      end else if (press[i]) begin
        rep_active_d[i] = 1'b1;
        rep_cnt_d[i]    = REP_DLY_LD;
      end else if (rep_active_q[i]) begin
        if (rep_cnt_q[i] == '0) begin
          out_d[i]     = 1'b1;
          rep_cnt_d[i] = REP_PER_LD;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '1;
      stable_dly_q <= '1;
      out_q        <= '0;
      deb_cnt_q    <= '0;
      rep_active_q <= '0;
      rep_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      out_q        <= out_d;
      deb_cnt_q    <= deb_cnt_d;
      rep_active_q <= rep_active_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  assign up   = out_q[0];
  assign dw   = out_q[1];
  assign lf   = out_q[2];
  assign rg   = out_q[3];
  assign prom = out_q[4];

endmodule
